// File: rtl/set_scan_sequencer.sv
// Sequencer for the 3-lane MapCell/CandidateAdder datapath of the SET engine:
// latches a circle job, scans the 8x8 grid per circle phase and gates the adder.
module set_scan_sequencer #(
  parameter int MAPCELL_LAT = 1,
  parameter int ADDER_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] central,
  input  logic [11:0] radius,
  input  logic [1:0]  mode,
  output logic [11:0] circle_A,
  output logic [11:0] circle_B,
  output logic [11:0] circle_C,
  output logic [1:0]  reg_mode,
  output logic [1:0]  phase,
  output logic [5:0]  now_0,
  output logic [5:0]  now_1,
  output logic [5:0]  now_2,
  output logic        MapCell_en,
  output logic [2:0]  lane_mask,
  output logic        Candidate_en,
  output logic [1:0]  phase_d,
  output logic        acc_clr,
  output logic        busy,
  output logic        valid
);
  // state | meaning
  // IDLE  | waiting for en (busy low, or still high during the valid cycle)
  // SCAN  | issuing 22 three-point groups per circle phase
  // DRAIN | lane and adder pipelines emptying, no issue
  // DONE  | candidate final; valid is registered out next cycle
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam int DRAIN_CYC = MAPCELL_LAT + ADDER_LAT;

  state_t          state, state_next;
  logic [5:0]      base, base_next;
  logic [1:0]      phase_cnt, phase_cnt_next, last_phase;
  logic [7:0]      drain_cnt, drain_next;
  logic            accept, iss_en;
  logic [2:0]      iss_mask, mask_q;
  logic [2:0][5:0] iss_now;
  logic [6:0]      lane_pt;
  logic [5:0]      pipe [MAPCELL_LAT];

  always_comb begin
    case (reg_mode)
      2'd0:    last_phase = 2'd0;
      2'd3:    last_phase = 2'd2;
      default: last_phase = 2'd1;
    endcase
  end

  always_comb begin
    state_next     = state;
    base_next      = base;
    phase_cnt_next = phase_cnt;
    drain_next     = drain_cnt;
    accept         = 1'b0;
    iss_en         = 1'b0;
    iss_mask       = '0;
    iss_now        = '0;
    lane_pt        = '0;
    case (state)
      IDLE: begin
        // busy is still high in the valid cycle, so a held en cannot re-trigger there
        if (en && !busy) begin
          accept         = 1'b1;
          state_next     = SCAN;
          base_next      = '0;
          phase_cnt_next = '0;
        end
      end
      SCAN: begin
        iss_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
          lane_pt = {1'b0, base} + 7'(k);
          if (!lane_pt[6]) begin
            iss_mask[k] = 1'b1;
            iss_now[k]  = lane_pt[5:0];
          end
        end
        if (base == 6'd63) begin
          base_next = '0;
          if (phase_cnt == last_phase) begin
            state_next = DRAIN;
            drain_next = 8'(DRAIN_CYC - 1);
          end else begin
            phase_cnt_next = phase_cnt + 2'd1;
          end
        end else begin
          base_next = base + 6'd3;
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) state_next = DONE;
        else                 drain_next = drain_cnt - 8'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      base       <= '0;
      phase_cnt  <= '0;
      drain_cnt  <= '0;
      circle_A   <= '0;
      circle_B   <= '0;
      circle_C   <= '0;
      reg_mode   <= '0;
      phase      <= '0;
      now_0      <= '0;
      now_1      <= '0;
      now_2      <= '0;
      MapCell_en <= 1'b0;
      mask_q     <= '0;
      acc_clr    <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      for (int i = 0; i < MAPCELL_LAT; i++) pipe[i] <= '0;
    end else begin
      state     <= state_next;
      base      <= base_next;
      phase_cnt <= phase_cnt_next;
      drain_cnt <= drain_next;
      if (accept) begin
        circle_A <= {central[23:16], radius[11:8]};
        circle_B <= {central[15:8],  radius[7:4]};
        circle_C <= {central[7:0],   radius[3:0]};
        reg_mode <= mode;
      end
      acc_clr <= accept;
      if (accept)     busy <= 1'b1;
      else if (valid) busy <= 1'b0;
      valid      <= (state == DONE);
      MapCell_en <= iss_en;
      mask_q     <= iss_mask;
      phase      <= iss_en ? phase_cnt : 2'd0;
      now_0      <= iss_now[0];
      now_1      <= iss_now[1];
      now_2      <= iss_now[2];
      // lane results appear MAPCELL_LAT cycles after issue; the adder strobe follows them
      pipe[0] <= {MapCell_en, mask_q, phase};
      for (int i = 1; i < MAPCELL_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign Candidate_en = pipe[MAPCELL_LAT-1][5];
  assign lane_mask    = pipe[MAPCELL_LAT-1][4:2];
  assign phase_d      = pipe[MAPCELL_LAT-1][1:0];

endmodule

// File: tb/tb_set_scan_sequencer.sv
// Scoreboard bench for set_scan_sequencer: stimulus queues expected job results,
// monitors at the falling edge pop and compare on acc_clr/valid.
module tb_set_scan_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        en2 = 1'b0;
  logic [23:0] central = '0;
  logic [11:0] radius = '0;
  logic [1:0]  mode = '0;

  logic [11:0] circle_A, circle_B, circle_C;
  logic [1:0]  reg_mode, phase, phase_d;
  logic [5:0]  now_0, now_1, now_2;
  logic        MapCell_en, Candidate_en, acc_clr, busy, valid;
  logic [2:0]  lane_mask;

  logic [11:0] circle_A_2, circle_B_2, circle_C_2;
  logic [1:0]  reg_mode_2, phase_2, phase_d_2;
  logic [5:0]  now_0_2, now_1_2, now_2_2;
  logic        MapCell_en_2, Candidate_en_2, acc_clr_2, busy_2, valid_2;
  logic [2:0]  lane_mask_2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    int          start;
    int          vrel;
    int          n;
    int          ph0, ph1, ph2;
    int          nsum;
    int          msum;
    int          zs;
    logic [1:0]  lastp;
    logic [11:0] ca, cb, cc;
    logic [1:0]  md;
  } exp_t;

  exp_t sb[$];
  int   sb2[$];

  set_scan_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius), .mode(mode),
    .circle_A(circle_A), .circle_B(circle_B), .circle_C(circle_C), .reg_mode(reg_mode),
    .phase(phase), .now_0(now_0), .now_1(now_1), .now_2(now_2), .MapCell_en(MapCell_en),
    .lane_mask(lane_mask), .Candidate_en(Candidate_en), .phase_d(phase_d),
    .acc_clr(acc_clr), .busy(busy), .valid(valid)
  );

  set_scan_sequencer #(.MAPCELL_LAT(2), .ADDER_LAT(1)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .central(central), .radius(radius), .mode(mode),
    .circle_A(circle_A_2), .circle_B(circle_B_2), .circle_C(circle_C_2), .reg_mode(reg_mode_2),
    .phase(phase_2), .now_0(now_0_2), .now_1(now_1_2), .now_2(now_2_2), .MapCell_en(MapCell_en_2),
    .lane_mask(lane_mask_2), .Candidate_en(Candidate_en_2), .phase_d(phase_d_2),
    .acc_clr(acc_clr_2), .busy(busy_2), .valid(valid_2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endfunction

  function automatic exp_t mk(int vrel, int n, logic [1:0] lastp,
                              logic [11:0] ca, logic [11:0] cb, logic [11:0] cc, logic [1:0] md);
    exp_t e;
    e.start = 0;
    e.vrel  = vrel;
    e.n     = n;
    e.ph0   = 22;
    e.ph1   = (n >= 44) ? 22 : 0;
    e.ph2   = (n == 66) ? 22 : 0;
    e.nsum  = 2016 * (n / 22);
    e.msum  = 64 * (n / 22);
    e.zs    = n / 22;
    e.lastp = lastp;
    e.ca = ca; e.cb = cb; e.cc = cc; e.md = md;
    return e;
  endfunction

  // ---------------- monitor for the default-latency instance ----------------
  bit         active = 0, chk_busy = 0;
  int         iss, cnd, nsum, msum, zs, bcnt, first_map, first_cnd, rel;
  int         pc[4];
  logic [5:0] l0, l1, l2;
  logic [2:0] lmask;
  logic [1:0] lphd;
  exp_t       ex;

  always @(negedge clk) begin
    if (!rst) begin
      active   = 0;
      chk_busy = 0;
    end else begin
      if (chk_busy) begin
        check("busy_after_valid", int'(busy), 0);
        chk_busy = 0;
      end
      if (acc_clr) begin
        if (sb.size() == 0) check("acc_clr_unexpected", 1, 0);
        else                check("acc_clr_cycle", cyc - sb[0].start, 0);
        active = 1;
        iss = 0; cnd = 0; nsum = 0; msum = 0; zs = 0; bcnt = 0;
        first_map = -1; first_cnd = -1;
        for (int i = 0; i < 4; i++) pc[i] = 0;
        l0 = '0; l1 = '0; l2 = '0; lmask = '0; lphd = '0;
      end
      if (active) begin
        rel = (sb.size() != 0) ? cyc - sb[0].start : 0;
        if (busy) bcnt++;
        if (MapCell_en) begin
          if (first_map < 0) first_map = rel;
          iss++;
          pc[phase]++;
          nsum += int'(now_0) + int'(now_1) + int'(now_2);
          if (now_0 == 6'd0) zs++;
          l0 = now_0; l1 = now_1; l2 = now_2;
        end
        if (Candidate_en) begin
          if (first_cnd < 0) first_cnd = rel;
          cnd++;
          msum += $countones(lane_mask);
          lmask = lane_mask;
          lphd  = phase_d;
          check("acc_clr_with_cand", int'(acc_clr), 0);
        end
      end
      if (valid) begin
        if (sb.size() == 0) begin
          check("valid_unexpected", 1, 0);
        end else begin
          ex = sb.pop_front();
          check("valid_cycle", cyc - ex.start, ex.vrel);
          check("issue_count", iss, ex.n);
          check("phase0_issues", pc[0], ex.ph0);
          check("phase1_issues", pc[1], ex.ph1);
          check("phase2_issues", pc[2], ex.ph2);
          check("phase3_issues", pc[3], 0);
          check("point_sum", nsum, ex.nsum);
          check("base_restarts", zs, ex.zs);
          check("final_group", int'({l0, l1, l2}), int'({6'd63, 6'd0, 6'd0}));
          check("first_mapcell", first_map, 1);
          check("first_cand", first_cnd, 2);
          check("cand_count", cnd, ex.n);
          check("mask_sum", msum, ex.msum);
          check("final_mask", int'(lmask), 1);
          check("final_phase_d", int'(lphd), int'(ex.lastp));
          check("busy_cycles", bcnt, ex.vrel + 1);
          check("circle_A", int'(circle_A), int'(ex.ca));
          check("circle_B", int'(circle_B), int'(ex.cb));
          check("circle_C", int'(circle_C), int'(ex.cc));
          check("reg_mode", int'(reg_mode), int'(ex.md));
          chk_busy = 1;
          active   = 0;
        end
      end
    end
  end

  // ---------------- monitor for the MAPCELL_LAT=2 instance ----------------
  int         fm2, fc2, cnd2, rel2;
  logic [2:0] lmask2;

  always @(negedge clk) begin
    if (rst) begin
      rel2 = (sb2.size() != 0) ? cyc - sb2[0] : 0;
      if (acc_clr_2) begin
        fm2 = -1; fc2 = -1; cnd2 = 0; lmask2 = '0;
      end
      if (MapCell_en_2 && fm2 < 0) fm2 = rel2;
      if (Candidate_en_2) begin
        if (fc2 < 0) fc2 = rel2;
        cnd2++;
        lmask2 = lane_mask_2;
      end
      if (valid_2) begin
        if (sb2.size() == 0) begin
          check("lat2_valid_unexpected", 1, 0);
        end else begin
          check("lat2_valid_cycle", cyc - sb2.pop_front(), 26);
          check("lat2_first_mapcell", fm2, 1);
          check("lat2_cand_lag", fc2 - fm2, 2);
          check("lat2_cand_count", cnd2, 22);
          check("lat2_final_mask", int'(lmask2), 1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                         input exp_t e, input bit hold, output int start);
    @(negedge clk);
    central = c; radius = r; mode = m; en = 1'b1;
    @(posedge clk);
    #1;
    start   = cyc;
    e.start = cyc;
    sb.push_back(e);
    if (!hold) begin
      en      = 1'b0;
      central = ~c; radius = ~r; mode = ~m;
    end
  endtask

  task automatic wait_jobs();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    check("job_timeout", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_circAB"}, int'({circle_A, circle_B}), 0);
    check({tag, "_circC_mode_phase"}, int'({circle_C, reg_mode, phase}), 0);
    check({tag, "_now"}, int'({now_0, now_1, now_2}), 0);
    check({tag, "_ctrl"}, int'({MapCell_en, lane_mask, Candidate_en, phase_d, acc_clr, busy, valid}), 0);
  endtask

  exp_t e;
  int   st;
  bit   found;

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("idle");

    e = mk(25, 22, 2'd0, 12'h123, 12'h340, 12'h567, 2'd0);
    run_job(24'h123456, 12'h307, 2'd0, e, 1'b0, st);
    wait_jobs();

    e = mk(47, 44, 2'd1, 12'h880, 12'h77F, 12'h112, 2'd1);
    run_job(24'h887711, 12'h0F2, 2'd1, e, 1'b0, st);
    wait_jobs();

    e = mk(47, 44, 2'd1, 12'h239, 12'h45A, 12'h67B, 2'd2);
    run_job(24'h234567, 12'h9AB, 2'd2, e, 1'b0, st);
    wait_jobs();

    e = mk(69, 66, 2'd2, 12'h814, 12'h815, 12'h816, 2'd3);
    run_job(24'h818181, 12'h456, 2'd3, e, 1'b0, st);
    wait_jobs();

    // abort a mode-3 job mid-scan
    e = mk(69, 66, 2'd2, 12'h814, 12'h815, 12'h816, 2'd3);
    run_job(24'h818181, 12'h456, 2'd3, e, 1'b0, st);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (MapCell_en && now_0 == 6'd30 && phase == 2'd0) found = 1;
    end
    check("reach_base30", int'(found), 1);
    #1 rst = 1'b0;
    #1;
    check_all_zero("abort");
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_valid", int'(valid), 0);

    e = mk(25, 22, 2'd0, 12'h123, 12'h340, 12'h567, 2'd0);
    run_job(24'h123456, 12'h307, 2'd0, e, 1'b0, st);
    wait_jobs();

    // en held high: second job only at the edge after busy drops
    e = mk(25, 22, 2'd0, 12'hAB1, 12'hCD2, 12'hEF3, 2'd0);
    run_job(24'hABCDEF, 12'h123, 2'd0, e, 1'b1, st);
    e.start = st + 27;
    sb.push_back(e);
    repeat (27) @(posedge clk);
    #1 en = 1'b0;
    wait_jobs();

    // longer lane latency instance
    @(negedge clk);
    central = 24'h111111; radius = 12'h111; mode = 2'd0; en2 = 1'b1;
    @(posedge clk);
    #1;
    sb2.push_back(cyc);
    en2 = 1'b0;
    for (int i = 0; i < 200 && sb2.size() != 0; i++) @(negedge clk);
    check("lat2_timeout", sb2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
